// File: rtl/tb_periph_master.sv
// Command-stream initiator for the HWPE peripheral port: issues req/gnt transactions,
// tracks outstanding responses by tag and returns them in order with error flags.
module tb_periph_master #(
    parameter int ID              = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [31:0]   cmd_addr_i,
    input  logic [31:0]   cmd_wdata_i,
    input  logic [3:0]    cmd_be_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_write_o,
    output logic          rsp_err_o,
    output logic          periph_req_o,
    input  logic          periph_gnt_i,
    output logic [31:0]   periph_add_o,
    output logic          periph_wen_o,
    output logic [3:0]    periph_be_o,
    output logic [31:0]   periph_data_o,
    output logic [ID-1:0] periph_id_o,
    input  logic [31:0]   periph_r_data_i,
    input  logic          periph_r_valid_i,
    input  logic [ID-1:0] periph_r_id_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [OW-1:0] MAX_OUTS  = OW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT - 1);

    logic                       req_q;
    logic [31:0]                add_q;
    logic                       wen_q;
    logic [3:0]                 be_q;
    logic [31:0]                data_q;
    logic [ID-1:0]              id_q;

    logic [OW-1:0]              outs_q;
    logic [ID-1:0]              issue_tag_q;
    logic [ID-1:0]              exp_tag_q;
    logic [MAX_OUTSTANDING-1:0] type_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [WW-1:0]              wd_q;
    logic                       err_q;

    logic                       rsp_valid_q;
    logic [31:0]                rsp_rdata_q;
    logic                       rsp_write_q;
    logic                       rsp_err_q;

    logic                       cmd_ready;
    logic                       cmd_fire;
    logic                       grant;
    logic                       rsp_hit;
    logic                       rsp_stray;
    logic                       id_bad;
    logic                       busy;
    logic                       progress;
    logic                       wd_fire;
    logic                       popped_write;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    assign cmd_ready    = ~req_q & (outs_q < MAX_OUTS) & ~err_q;
    assign cmd_fire     = cmd_valid_i & cmd_ready;
    assign grant        = req_q & periph_gnt_i;
    assign rsp_hit      = periph_r_valid_i & (outs_q != '0);
    assign rsp_stray    = periph_r_valid_i & (outs_q == '0);
    assign id_bad       = periph_r_id_i != exp_tag_q;
    assign busy         = req_q | (outs_q != '0);
    assign progress     = grant | periph_r_valid_i;
    assign wd_fire      = busy & ~progress & (wd_q == WD_LIMIT);
    assign popped_write = type_q[rd_ptr_q];

    // Request register: held stable from handshake until granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            add_q  <= '0;
            wen_q  <= 1'b1;
            be_q   <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else if (clear_i) begin
            req_q  <= 1'b0;
            add_q  <= '0;
            wen_q  <= 1'b1;
            be_q   <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else if (cmd_fire) begin
            req_q  <= 1'b1;
            add_q  <= cmd_addr_i;
            wen_q  <= ~cmd_write_i;
            be_q   <= cmd_be_i;
            data_q <= cmd_wdata_i;
            id_q   <= issue_tag_q;
        end else if (grant) begin
            req_q  <= 1'b0;
        end
    end

    // Outstanding tracking: counter, tags, in-order type FIFO, watchdog and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outs_q      <= '0;
            issue_tag_q <= '0;
            exp_tag_q   <= '0;
            type_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else if (clear_i) begin
            outs_q      <= '0;
            issue_tag_q <= '0;
            exp_tag_q   <= '0;
            type_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            case ({grant, rsp_hit})
                2'b10:   outs_q <= outs_q + 1'b1;
                2'b01:   outs_q <= outs_q - 1'b1;
                default: outs_q <= outs_q;
            endcase
            if (grant) begin
                issue_tag_q      <= issue_tag_q + 1'b1;
                type_q[wr_ptr_q] <= ~wen_q;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (rsp_hit) begin
                exp_tag_q <= exp_tag_q + 1'b1;
                rd_ptr_q  <= next_ptr(rd_ptr_q);
            end
            if (!busy || progress) begin
                wd_q <= '0;
            end else if (wd_q != WD_LIMIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (rsp_stray || (rsp_hit && id_bad) || wd_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    // Response strobe lags the bus response by one cycle; write data is never echoed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (clear_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_hit;
            rsp_rdata_q <= (rsp_hit && !popped_write) ? periph_r_data_i : '0;
            rsp_write_q <= rsp_hit & popped_write;
            rsp_err_q   <= rsp_hit & id_bad;
        end
    end

    assign cmd_ready_o   = cmd_ready;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_write_o   = rsp_write_q;
    assign rsp_err_o     = rsp_err_q;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_be_o   = be_q;
    assign periph_data_o = data_q;
    assign periph_id_o   = id_q;
    assign busy_o        = busy;
    assign err_o         = err_q;

endmodule

// File: tb/tb_tb_periph_master.sv
// Bench for tb_periph_master: a command driver, a behavioural periph target with a register
// memory, and a scoreboard of expected in-order responses.
module tb_tb_periph_master;

    localparam int ID   = 10;
    localparam int MAXO = 4;
    localparam int TO   = 16;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          clear     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [31:0]   cmd_addr  = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_be    = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_write;
    logic          rsp_err;
    logic          periph_req;
    logic          periph_gnt;
    logic [31:0]   periph_add;
    logic          periph_wen;
    logic [3:0]    periph_be;
    logic [31:0]   periph_data;
    logic [ID-1:0] periph_id;
    logic [31:0]   r_data    = '0;
    logic          r_valid   = 1'b0;
    logic [ID-1:0] r_id      = '0;
    logic          busy;
    logic          err;

    logic gnt_en     = 1'b0;
    logic rsp_hold   = 1'b0;
    logic stray_req  = 1'b0;
    int   rsp_delay  = 2;
    int   corrupt_idx = -1;
    int   cmd_seq    = 0;
    int   rsp_seq    = 0;
    int   rsp_count  = 0;
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        write;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [ID-1:0] id;
        logic [31:0]   rdata;
        logic [31:0]   ready;
    } pend_t;

    cmd_t          cmd_q[$];
    exp_t          sb_q[$];
    pend_t         tgt_q[$];
    logic [ID-1:0] gnt_ids[$];
    logic [31:0]   ref_mem[logic [31:0]];
    logic [31:0]   tgt_mem[logic [31:0]];

    assign periph_gnt = gnt_en;

    tb_periph_master #(.ID(ID), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_write_o(rsp_write), .rsp_err_o(rsp_err),
        .periph_req_o(periph_req), .periph_gnt_i(periph_gnt), .periph_add_o(periph_add),
        .periph_wen_o(periph_wen), .periph_be_o(periph_be), .periph_data_o(periph_data),
        .periph_id_o(periph_id), .periph_r_data_i(r_data), .periph_r_valid_i(r_valid),
        .periph_r_id_i(r_id), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        c.be    = be;
        cmd_q.push_back(c);
    endtask

    task automatic preset_mem(input logic [31:0] addr, input logic [31:0] val);
        ref_mem[addr] = val;
        tgt_mem[addr] = val;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!periph_req && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(periph_req), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || cmd_valid || cmd_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        sb_q.delete();
        tgt_q.delete();
        gnt_ids.delete();
        cmd_seq = 0;
        rsp_seq = 0;
    endtask

    // Command driver: expectations are recorded at the handshake, in issue order.
    initial begin : driver
        logic        hs;
        cmd_t        c;
        exp_t        e;
        logic [31:0] old;
        forever begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (hs && cmd_q.size() > 0) begin
                c   = cmd_q.pop_front();
                old = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0;
                e.write = c.write;
                e.err   = (cmd_seq == corrupt_idx);
                if (c.write) begin
                    e.rdata = 32'h0;
                    ref_mem[c.addr] = merge_be(old, c.wdata, c.be);
                end else begin
                    e.rdata = old;
                end
                sb_q.push_back(e);
                cmd_seq++;
                cmd_valid = 1'b0;
            end
            if (!cmd_valid && cmd_q.size() > 0) begin
                cmd_write = cmd_q[0].write;
                cmd_addr  = cmd_q[0].addr;
                cmd_wdata = cmd_q[0].wdata;
                cmd_be    = cmd_q[0].be;
                cmd_valid = 1'b1;
            end
        end
    end

    // Periph target: accepts grants, answers rsp_delay cycles later, may corrupt one tag.
    initial begin : target
        pend_t       p;
        logic [31:0] old;
        forever begin
            @(negedge clk);
            if (periph_req && periph_gnt) begin
                gnt_ids.push_back(periph_id);
                old = tgt_mem.exists(periph_add) ? tgt_mem[periph_add] : 32'h0;
                if (!periph_wen) begin
                    tgt_mem[periph_add] = merge_be(old, periph_data, periph_be);
                    p.rdata = $urandom;
                end else begin
                    p.rdata = old;
                end
                p.id    = periph_id;
                p.ready = 32'(cyc + rsp_delay);
                tgt_q.push_back(p);
            end
            @(posedge clk);
            #1;
            if (stray_req) begin
                r_valid   = 1'b1;
                r_id      = '0;
                r_data    = 32'h5A5A_5A5A;
                stray_req = 1'b0;
            end else if (!rsp_hold && tgt_q.size() > 0 && tgt_q[0].ready <= 32'(cyc)) begin
                p       = tgt_q.pop_front();
                r_valid = 1'b1;
                r_id    = (rsp_seq == corrupt_idx) ? ID'(7) : p.id;
                r_data  = p.rdata;
                rsp_seq++;
            end else begin
                r_valid = 1'b0;
                r_id    = '0;
                r_data  = '0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            rsp_count++;
            if (sb_q.size() == 0) begin
                checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_write", 32'(rsp_write), 32'(e.write));
                checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin : timeout_guard
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int rc;
        rst = 1'b1;
        tick(2);
        checkOutput("rst_req", 32'(periph_req), 32'd0);
        checkOutput("rst_wen", 32'(periph_wen), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick(1);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] single write, immediate grant");
        gnt_en = 1'b1;
        applyStimulus(1'b1, 32'h0010_0000, 32'hDEAD_BEEF, 4'hF);
        wait_req("t1_req_seen", 10);
        checkOutput("t1_wen", 32'(periph_wen), 32'd0);
        checkOutput("t1_id", 32'(periph_id), 32'd0);
        checkOutput("t1_add", periph_add, 32'h0010_0000);
        checkOutput("t1_data", periph_data, 32'hDEAD_BEEF);
        checkOutput("t1_be", 32'(periph_be), 32'hF);
        tick(1);
        checkOutput("t1_req_one_cycle", 32'(periph_req), 32'd0);
        checkOutput("t1_busy_outstanding", 32'(busy), 32'd1);
        tick(2);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);
        wait_idle("t1_idle", 20);

        $display("[TB] read with grant stall");
        preset_mem(32'h0010_0004, 32'h0000_00A5);
        gnt_en = 1'b0;
        applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
        wait_req("t2_req_seen", 10);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2_req_hold%0d", i), 32'(periph_req), 32'd1);
            checkOutput($sformatf("t2_add_hold%0d", i), periph_add, 32'h0010_0004);
            checkOutput($sformatf("t2_id_hold%0d", i), 32'(periph_id), 32'd1);
            checkOutput($sformatf("t2_wen_hold%0d", i), 32'(periph_wen), 32'd1);
            checkOutput($sformatf("t2_ready_low%0d", i), 32'(cmd_ready), 32'd0);
            tick(1);
        end
        checkOutput("t2_req_sixth", 32'(periph_req), 32'd1);
        gnt_en = 1'b1;
        tick(1);
        checkOutput("t2_req_dropped", 32'(periph_req), 32'd0);
        wait_idle("t2_idle", 20);

        $display("[TB] outstanding limit");
        pulse_clear();
        rsp_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            preset_mem(32'h0010_0100 + 32'(4 * i), 32'h0000_1000 + 32'(i));
            applyStimulus(1'b0, 32'h0010_0100 + 32'(4 * i), 32'h0, 4'hF);
        end
        tick(14);
        checkOutput("t3_grants_capped", 32'(gnt_ids.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t3_gnt_id%0d", i),
                        (gnt_ids.size() > i) ? 32'(gnt_ids[i]) : 32'hFFFF_FFFF, 32'(i));
        checkOutput("t3_ready_low", 32'(cmd_ready), 32'd0);
        rc = rsp_count;
        rsp_hold = 1'b0;
        wait_idle("t3_idle", 80);
        checkOutput("t3_grants_total", 32'(gnt_ids.size()), 32'd6);
        for (int i = 4; i < 6; i++)
            checkOutput($sformatf("t3_gnt_id%0d", i),
                        (gnt_ids.size() > i) ? 32'(gnt_ids[i]) : 32'hFFFF_FFFF, 32'(i));
        checkOutput("t3_rsp_count", 32'(rsp_count - rc), 32'd6);
        checkOutput("t3_err_clean", 32'(err), 32'd0);

        $display("[TB] tag mismatch on third response");
        pulse_clear();
        corrupt_idx = 2;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0010_0100 + 32'(4 * i), 32'h0, 4'hF);
        wait_idle("t4_idle", 40);
        checkOutput("t4_err_set", 32'(err), 32'd1);
        tick(3);
        checkOutput("t4_err_sticky", 32'(err), 32'd1);
        checkOutput("t4_ready_blocked", 32'(cmd_ready), 32'd0);
        pulse_clear();
        corrupt_idx = -1;
        checkOutput("t4_err_cleared", 32'(err), 32'd0);
        checkOutput("t4_ready_back", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, 32'h0010_0200, 32'h1234_5678, 4'h3);
        wait_req("t4_req_seen", 10);
        checkOutput("t4_tag_reset", 32'(periph_id), 32'd0);
        wait_idle("t4_idle2", 20);

        $display("[TB] watchdog");
        gnt_en = 1'b0;
        applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
        wait_req("t5_req_seen", 10);
        tick(15);
        checkOutput("t5_err_before", 32'(err), 32'd0);
        tick(1);
        checkOutput("t5_err_fired", 32'(err), 32'd1);
        checkOutput("t5_req_held", 32'(periph_req), 32'd1);
        gnt_en = 1'b1;
        wait_idle("t5_idle", 20);
        checkOutput("t5_err_sticky", 32'(err), 32'd1);

        $display("[TB] async reset with two outstanding");
        pulse_clear();
        rsp_hold = 1'b1;
        applyStimulus(1'b0, 32'h0010_0100, 32'h0, 4'hF);
        applyStimulus(1'b0, 32'h0010_0104, 32'h0, 4'hF);
        for (int n = 0; n < 20 && (gnt_ids.size() < 2 || periph_req); n++) tick(1);
        checkOutput("t6_two_granted", 32'(gnt_ids.size()), 32'd2);
        checkOutput("t6_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_req_async", 32'(periph_req), 32'd0);
        checkOutput("t6_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        tgt_q.delete();
        gnt_ids.delete();
        cmd_seq  = 0;
        rsp_seq  = 0;
        rsp_hold = 1'b0;
        rc = rsp_count;
        tick(1);
        checkOutput("t6_err_after_reset", 32'(err), 32'd0);
        stray_req = 1'b1;
        tick(4);
        checkOutput("t6_no_rsp", 32'(rsp_count - rc), 32'd0);
        checkOutput("t6_err_stray", 32'(err), 32'd1);
        checkOutput("t6_busy_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tb_periph_master.md
Name: tb_periph_master

Overview:
- Synthesizable initiator for the HWPE peripheral (register-file) port; the opposite end of the HWPE periph target.
- Converts a simple command stream into periph req/gnt transactions and tracks outstanding responses with ID tags.
- Returns in-order responses with protocol checking.
- Lets benches and standalone subsystems program HWPEs without a core.

Parameters:
- ID, 10, width of periph_id/periph_r_id.
- MAX_OUTSTANDING, 4, max granted-but-unanswered transactions (power of 2, >=1).
- TIMEOUT, 1024, cycles without progress before the watchdog fires (>=2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous clear; same effect as reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  32  register address.
- cmd_wdata_i  in  32  write data.
- cmd_be_i  in  4  byte enables.
- rsp_valid_o  out  1  response strobe, one cycle, no backpressure.
- rsp_rdata_o  out  32  read data (0 for writes).
- rsp_write_o  out  1  response belongs to a write.
- rsp_err_o  out  1  ID mismatch on this response.
- periph_req_o  out  1  request.
- periph_gnt_i  in  1  grant.
- periph_add_o  out  32  address.
- periph_wen_o  out  1  active-low write enable (0=write).
- periph_be_o  out  4  byte enables.
- periph_data_o  out  32  write data.
- periph_id_o  out  ID  transaction tag.
- periph_r_data_i  in  32  response data.
- periph_r_valid_i  in  1  response valid (for reads and writes).
- periph_r_id_i  in  ID  response tag.
- busy_o  out  1  request pending or responses outstanding.
- err_o  out  1  sticky error: ID mismatch, unexpected response, or timeout.

Behaviour:
- Reset/clear: all outputs 0 except periph_wen_o=1. Counters, tag counters, type FIFO and err_o cleared. Async reset drops periph_req_o immediately; in-flight transactions are forgotten.
- cmd_ready_o = ~req_q & (outs_q < MAX_OUTSTANDING) & ~err_o (registered terms only). Peak throughput is 1 command per 2 cycles.
- On cmd handshake, latch the command into the request register; periph_req_o=1 from the next cycle.
  - periph_id_o = issue_tag_q.
  - periph_wen_o = ~cmd_write_i.
- Request hold: while req&~gnt, add/wen/be/data/id stay stable and req stays high. Req is never withdrawn except by reset/clear.
- Grant (req&gnt):
  - req_q drops next cycle.
  - issue_tag_q increments, mod 2^ID.
  - outs_q increments.
  - The write bit is pushed into the in-order type FIFO (depth MAX_OUTSTANDING).
- Response (r_valid) with outs_q>0:
  - Pop the type FIFO; outs_q decrements.
  - One cycle later: rsp_valid_o=1, rsp_rdata_o=r_data (forced 0 if write), rsp_write_o=popped bit.
  - rsp_err_o = (r_id != exp_tag_q). exp_tag_q increments mod 2^ID.
  - Mismatch also sets err_o.
- Simultaneous grant and response: outs_q unchanged; FIFO push and pop in the same cycle are legal, including when full.
- Response with outs_q==0: no rsp_valid_o; err_o set; counters unchanged.
- Zero-latency response (r_valid in the grant cycle) is illegal and is treated as unexpected if outs_q==0.
- Watchdog:
  - wd_q resets to 0 on any grant or response, or when not busy.
  - Otherwise it increments while busy.
  - When wd_q reaches TIMEOUT-1, err_o is set and wd_q saturates.
- err_o is sticky until reset/clear and blocks new commands. The pending request and outstanding responses continue to complete normally.
- busy_o = req_q | (outs_q != 0).

Test Plan:
- Write: cmd addr 0x0010_0000, wdata 0xDEADBEEF, be 0xF; gnt same cycle as req; r_valid 2 cycles later -> req high exactly 1 cycle, wen=0, id=0; rsp_valid 1 cycle after r_valid with rsp_write=1, rdata=0; busy_o low the cycle after.
- Grant stall: read addr 0x0010_0004, gnt low 5 cycles -> req held 6 cycles; add/id/wen=1 stable; cmd_ready_o low throughout; then r_data 0x0000_00A5 -> rsp_rdata_o=0x0000_00A5.
- Outstanding limit: 6 back-to-back reads, gnt=1, responses withheld -> exactly 4 grants (ids 0..3), cmd_ready_o low. Release responses -> remaining 2 issue (ids 4,5); 6 responses in order, rsp_err_o=0.
- ID mismatch: third response returns r_id=7, expected 2 -> that rsp has rsp_err_o=1; err_o stays 1; cmd_ready_o=0 until clear_i; after clear_i all counters and tags are 0.
- Timeout with TIMEOUT=16: gnt held 0 -> err_o rises 16 cycles after req asserted; req still held. Later gnt+r_valid -> normal rsp, err_o stays 1.
- Async reset mid-transaction: assert rst_i between clock edges with 2 outstanding -> periph_req_o/busy_o 0 immediately. Stray r_valid after release -> no rsp_valid_o, err_o=1.
